data_sram_responder: RTL and testbench

- Slave (responder) end of the data-side SRAM-like handshake (req/wr/size/wstrb/addr/wdata -> addr_ok/data_ok/rdata) driven by the EX/MEM stages.
- Backed by an internal word-addressed memory.
- Accepts at most one request per cycle and returns responses strictly in order after a fixed latency.
- Supports several outstanding requests.
- Serves as the data-memory model in simulation and as the on-chip data RAM front end.

---
 rtl/data_sram_responder_pkg.sv | 16 +
 rtl/data_sram_responder_resp_fifo.sv | 75 +++++++
 rtl/data_sram_responder.sv | 104 ++++++++++
 tb/tb_data_sram_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-side SRAM responder: access size codes and
// the layout of one pending-response entry.
package data_sram_responder_pkg;

  // Access size encodings carried on the size port
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Response entry: {is_write, data[31:0]}
  localparam int ENTRY_DATA_LSB = 0;
  localparam int ENTRY_DATA_W   = 32;
  localparam int ENTRY_WR_BIT   = 32;
  localparam int ENTRY_W        = 33;

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order pending-response queue. Every entry carries a down-counter loaded
// at push; the head may leave only once its counter has reached zero, so a
// younger entry can finish counting while it waits behind an older one.
module resp_fifo #(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2,
  parameter int WIDTH   = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             head_ready,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TMR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [TMR_W-1:0] timer_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap explicitly so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_data  = data_q[rd_ptr];
  assign head_ready = !empty && (timer_q[rd_ptr] == '0);

  // Entry payload storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) data_q[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and per-entry latency counters
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) timer_q[i] <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (PTR_W'(i) == wr_ptr))
          timer_q[i] <= TMR_W'(LATENCY - 1);
        else if (timer_q[i] != '0)
          timer_q[i] <= timer_q[i] - TMR_W'(1);
      end
    end
  end

  // Queue invariants: no underflow, no overflow, occupancy bounded
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pop && empty));
      assert (!(push && full && !pop));
      assert (count <= CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the data-side SRAM-like handshake. Requests are accepted
// at most one per cycle into a word-addressed memory; responses come back in
// order after a fixed latency through the pending-response queue.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2      = 12,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RESP_LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  full;
  logic                  fifo_empty;
  logic                  head_ready;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic                  unused_bits;

  // Replace only the byte lanes whose strobe is set
  function automatic logic [31:0] strobe_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++)
      if (strb[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    return merged;
  endfunction

  assign idx         = addr[DEPTH_LOG2+1:2];
  assign unused_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0], size};

  // A full queue can still take a request in the cycle its head leaves
  assign addr_ok = req & ~stall & (~full | head_ready);
  assign accept  = req & addr_ok;

  // Read data is captured at acceptance; write responses carry zero data
  always_comb begin
    push_entry = '0;
    push_entry[ENTRY_WR_BIT] = wr;
    push_entry[ENTRY_DATA_LSB +: ENTRY_DATA_W] = wr ? 32'd0 : mem[idx];
  end

  // Memory write port: strobe-merged update on an accepted write
  always_ff @(posedge clk) begin
    if (accept && wr) mem[idx] <= strobe_merge(mem[idx], wdata, wstrb);
  end

  resp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .LATENCY (RESP_LATENCY),
    .WIDTH   (ENTRY_W)
  ) u_resp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .pop        (head_ready),
    .push_data  (push_entry),
    .head_data  (head_entry),
    .head_ready (head_ready),
    .full       (full),
    .empty      (fifo_empty)
  );

  // Registered response; rdata holds its last value between responses
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= head_ready;
      if (head_ready)
        rdata <= head_entry[ENTRY_WR_BIT] ? 32'd0
                                          : head_entry[ENTRY_DATA_LSB +: ENTRY_DATA_W];
    end
  end

  // Request-side invariants
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) assert (size <= SIZE_W);
      if (head_ready) assert (!fifo_empty);
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: a vector table of single
// transactions plus hand-written multi-cycle sequences.
module tb_data_sram_responder;

  localparam int LAT_A = 2;

  logic        clk;
  logic        reset;

  logic        req_a, wr_a, stall_a, addr_ok_a, data_ok_a;
  logic [1:0]  size_a;
  logic [3:0]  wstrb_a;
  logic [31:0] addr_a, wdata_a, rdata_a;

  logic        req_b, wr_b, stall_b, addr_ok_b, data_ok_b;
  logic [1:0]  size_b;
  logic [3:0]  wstrb_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int n_cmp;
  int n_err;
  int lat;
  int got;
  int first_c;
  int last_c;
  logic seen;
  logic exp_ok;
  logic [31:0] b2b_exp [4];

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [16];

  data_sram_responder #(.DEPTH_LOG2(12), .MAX_OUTSTANDING(2), .RESP_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .wr(wr_a), .size(size_a), .wstrb(wstrb_a),
    .addr(addr_a), .wdata(wdata_a), .stall(stall_a),
    .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a));

  data_sram_responder #(.DEPTH_LOG2(12), .MAX_OUTSTANDING(1), .RESP_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .wr(wr_b), .size(size_b), .wstrb(wstrb_b),
    .addr(addr_b), .wdata(wdata_b), .stall(stall_b),
    .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One isolated transaction on dut_a; starts and ends just after a posedge
  task automatic txn_a(input string name, input vec_t v);
    wr_a = v.wr; size_a = v.size; wstrb_a = v.wstrb;
    addr_a = v.addr; wdata_a = v.wdata; req_a = 1'b1;
    @(negedge clk);
    chk({name, "_addr_ok"}, {31'd0, addr_ok_a}, 32'd1);
    @(posedge clk); #1;
    req_a = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = data_ok_a;
    end
    chk({name, "_latency"}, 32'(lat), 32'(LAT_A));
    chk({name, "_rdata"}, rdata_a, v.exp_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    vecs[0]  = '{1'b1, 2'd2, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 2'd2, 4'b0000, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 2'd2, 4'b1111, 32'h0000_0200, 32'h1122_3344, 32'h0};
    vecs[3]  = '{1'b1, 2'd0, 4'b0100, 32'h0000_0202, 32'h00AA_0000, 32'h0};
    vecs[4]  = '{1'b0, 2'd2, 4'b0000, 32'h0000_0200, 32'h0,         32'h11AA_3344};
    vecs[5]  = '{1'b1, 2'd2, 4'b1111, 32'h0000_0300, 32'hCAFE_F00D, 32'h0};
    vecs[6]  = '{1'b1, 2'd2, 4'b0000, 32'h0000_0300, 32'hFFFF_FFFF, 32'h0};
    vecs[7]  = '{1'b0, 2'd1, 4'b0000, 32'h0000_0300, 32'h0,         32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 2'd2, 4'b1111, 32'h0000_0400, 32'h1234_5678, 32'h0};
    vecs[9]  = '{1'b1, 2'd1, 4'b1100, 32'h0000_0402, 32'hBEEF_0000, 32'h0};
    vecs[10] = '{1'b0, 2'd0, 4'b0000, 32'hFFFF_4401, 32'h0,         32'hBEEF_5678};
    vecs[11] = '{1'b1, 2'd2, 4'b1111, 32'h0000_0000, 32'hA0A0_A0A0, 32'h0};
    vecs[12] = '{1'b1, 2'd2, 4'b1111, 32'h0000_0004, 32'hB1B1_B1B1, 32'h0};
    vecs[13] = '{1'b1, 2'd2, 4'b1111, 32'h0000_0008, 32'hC2C2_C2C2, 32'h0};
    vecs[14] = '{1'b1, 2'd2, 4'b1111, 32'h0000_000C, 32'hD3D3_D3D3, 32'h0};
    vecs[15] = '{1'b0, 2'd2, 4'b0000, 32'h0000_0000, 32'h0,         32'hA0A0_A0A0};
    b2b_exp[0] = 32'hA0A0_A0A0; b2b_exp[1] = 32'hB1B1_B1B1;
    b2b_exp[2] = 32'hC2C2_C2C2; b2b_exp[3] = 32'hD3D3_D3D3;

    reset = 1'b1;
    req_a = 0; wr_a = 0; size_a = 2'd2; wstrb_a = 0; addr_a = 0; wdata_a = 0; stall_a = 0;
    req_b = 0; wr_b = 0; size_b = 2'd2; wstrb_b = 0; addr_b = 0; wdata_b = 0; stall_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_data_ok_a", {31'd0, data_ok_a}, 32'd0);
    chk("reset_rdata_a", rdata_a, 32'd0);
    chk("reset_addr_ok_a", {31'd0, addr_ok_a}, 32'd0);
    chk("reset_data_ok_b", {31'd0, data_ok_b}, 32'd0);
    chk("reset_rdata_b", rdata_b, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) txn_a($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back reads of four words
    got = 0; first_c = -1; last_c = -1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      req_a = (cyc < 4); wr_a = 1'b0; size_a = 2'd2; addr_a = 32'(cyc * 4);
      @(negedge clk);
      if (cyc < 4) chk($sformatf("b2b_addr_ok_c%0d", cyc), {31'd0, addr_ok_a}, 32'd1);
      if (data_ok_a) begin
        if (got < 4) chk($sformatf("b2b_rdata%0d", got), rdata_a, b2b_exp[got]);
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        got++;
      end
      @(posedge clk); #1;
    end
    req_a = 1'b0;
    chk("b2b_count", 32'(got), 32'd4);
    chk("b2b_first", 32'(first_c), 32'd3);
    chk("b2b_last", 32'(last_c), 32'd6);

    // Read of a word written in the immediately preceding cycle
    for (int cyc = 0; cyc < 6; cyc++) begin
      req_a = (cyc < 2); wr_a = (cyc == 0); size_a = 2'd2; wstrb_a = 4'b1111;
      addr_a = 32'h0000_0500; wdata_a = 32'h5566_7788;
      @(negedge clk);
      exp_ok = (cyc == 3) || (cyc == 4);
      chk($sformatf("raw_data_ok_c%0d", cyc), {31'd0, data_ok_a}, {31'd0, exp_ok});
      if (cyc == 3) chk("raw_wr_rdata", rdata_a, 32'h0);
      if (cyc == 4) chk("raw_rd_rdata", rdata_a, 32'h5566_7788);
      @(posedge clk); #1;
    end
    req_a = 1'b0; wr_a = 1'b0;

    // Stall blocks acceptance while a queued response still drains
    for (int cyc = 0; cyc < 11; cyc++) begin
      req_a = (cyc <= 6); stall_a = (cyc >= 1 && cyc <= 5); wr_a = 1'b0;
      addr_a = (cyc == 0) ? 32'h0000_0100 : 32'h0000_0200;
      @(negedge clk);
      exp_ok = (cyc == 0) || (cyc == 6);
      chk($sformatf("stall_addr_ok_c%0d", cyc), {31'd0, addr_ok_a}, {31'd0, exp_ok});
      exp_ok = (cyc == 3) || (cyc == 9);
      chk($sformatf("stall_data_ok_c%0d", cyc), {31'd0, data_ok_a}, {31'd0, exp_ok});
      if (cyc == 3) chk("stall_rdata0", rdata_a, 32'hDEAD_BEEF);
      if (cyc == 9) chk("stall_rdata1", rdata_a, 32'h11AA_3344);
      @(posedge clk); #1;
    end
    req_a = 1'b0; stall_a = 1'b0;

    // Reset while two reads are pending discards both responses
    for (int cyc = 0; cyc < 9; cyc++) begin
      req_a = (cyc < 2); wr_a = 1'b0; addr_a = 32'(cyc * 4);
      reset = (cyc == 2);
      @(negedge clk);
      if (cyc < 2) chk($sformatf("rst_addr_ok_c%0d", cyc), {31'd0, addr_ok_a}, 32'd1);
      chk($sformatf("rst_data_ok_c%0d", cyc), {31'd0, data_ok_a}, 32'd0);
      if (cyc == 3) chk("rst_rdata_cleared", rdata_a, 32'h0);
      @(posedge clk); #1;
    end
    req_a = 1'b0; reset = 1'b0;
    txn_a("post_reset_read", vecs[4]);

    // Single-entry queue with latency 3: one acceptance every three cycles
    for (int cyc = 0; cyc < 14; cyc++) begin
      req_b = (cyc < 12); wr_b = 1'b1; wstrb_b = 4'b1111;
      addr_b = 32'(cyc * 4); wdata_b = 32'(cyc);
      @(negedge clk);
      exp_ok = (cyc < 12) && (cyc % 3 == 0);
      chk($sformatf("full_addr_ok_c%0d", cyc), {31'd0, addr_ok_b}, {31'd0, exp_ok});
      exp_ok = (cyc >= 4) && (cyc % 3 == 1);
      chk($sformatf("full_data_ok_c%0d", cyc), {31'd0, data_ok_b}, {31'd0, exp_ok});
      if (exp_ok) chk($sformatf("full_rdata_c%0d", cyc), rdata_b, 32'h0);
      @(posedge clk); #1;
    end
    req_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
